// File: rtl/scan_pkg.sv
// Shared types and limits for the scan unload transmitter.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } scan_state_t;

  localparam int SCAN_MAX_WIDTH = 32;

endpackage

// File: rtl/scan_unload_tx.sv
// Serial unload transmitter: loads a captured parallel word on START and
// shifts it out one bit per accepted cycle on a valid/ready serial port.
module scan_unload_tx
  import scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic [WIDTH-1:0] PDATA,
  input  logic             READY,
  output logic             SO,
  output logic             SO_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2 || WIDTH > SCAN_MAX_WIDTH) begin : g_bad_width
      $error("scan_unload_tx: WIDTH must be in 2..32");
    end
  endgenerate

  scan_state_t      r_state;
  scan_state_t      w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_count;
  logic             w_load;
  logic             w_accept;

  always_ff @(posedge CLK) begin
    if (!R) r_state <= S_IDLE;
    else    r_state <= w_next;
  end

  // Outputs depend only on registered state and the shift register, never on inputs.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_accept = 1'b0;
    SO       = 1'b0;
    SO_VALID = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        BUSY     = 1'b1;
        SO_VALID = 1'b1;
        SO       = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
        if (READY) begin
          w_accept = 1'b1;
          if (r_count == CW'(1)) w_next = S_DONE;
        end
      end
      S_DONE: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= PDATA;
    end else if (w_accept) begin
      r_shreg <= MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  // Leaving SHIFT on the count-1 accept means the counter never reaches a wrap.
  always_ff @(posedge CLK) begin
    if (!R) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= CW'(WIDTH);
    end else if (w_accept) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_scan_unload_tx.sv
// Scoreboard bench: an MSB-first and an LSB-first instance run in lockstep
// on shared inputs; expected bits and DONE markers are queued per instance.
module tb_scan_unload_tx;

  typedef struct packed {
    logic isDone;
    logic bitVal;
  } exp_t;

  logic       CLK = 1'b0;
  logic       R = 1'b0;
  logic       START = 1'b0;
  logic [7:0] PDATA = 8'h00;
  logic       READY = 1'b0;
  logic       soM, vldM, busyM, doneM;
  logic       soL, vldL, busyL, doneL;

  exp_t qM[$];
  exp_t qL[$];
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  scan_unload_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dutM (
    .CLK(CLK), .R(R), .START(START), .PDATA(PDATA), .READY(READY),
    .SO(soM), .SO_VALID(vldM), .BUSY(busyM), .DONE(doneM)
  );

  scan_unload_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dutL (
    .CLK(CLK), .R(R), .START(START), .PDATA(PDATA), .READY(READY),
    .SO(soL), .SO_VALID(vldL), .BUSY(busyL), .DONE(doneL)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int qSize(input int idx);
    return (idx == 0) ? qM.size() : qL.size();
  endfunction

  function automatic exp_t qPeek(input int idx);
    return (idx == 0) ? qM[0] : qL[0];
  endfunction

  function automatic exp_t qPop(input int idx);
    if (idx == 0) return qM.pop_front();
    return qL.pop_front();
  endfunction

  // MSB instance expects bit 7 down; LSB instance expects bit 0 up.
  task automatic pushWord(input logic [7:0] pdata, input int nBits, input bit withDone);
    for (int i = 0; i < nBits; i++) begin
      qM.push_back(exp_t'{isDone: 1'b0, bitVal: pdata[7-i]});
      qL.push_back(exp_t'{isDone: 1'b0, bitVal: pdata[i]});
    end
    if (withDone) begin
      qM.push_back(exp_t'{isDone: 1'b1, bitVal: 1'b0});
      qL.push_back(exp_t'{isDone: 1'b1, bitVal: 1'b0});
    end
  endtask

  task automatic checkOutput(input int idx, input logic so, input logic vld,
                             input logic rdy, input logic dn);
    string tag;
    exp_t  e;
    tag = (idx == 0) ? "msb" : "lsb";
    if (vld === 1'b1 && rdy === 1'b1) begin
      if (qSize(idx) == 0) begin
        check({tag, "_unexpected_accept"}, 32'd1, 32'd0);
      end else begin
        e = qPop(idx);
        check({tag, "_accept_is_bit"}, {31'd0, e.isDone}, 32'd0);
        check({tag, "_bit"}, {31'd0, so}, {31'd0, e.bitVal});
      end
    end else if (vld === 1'b1 && rdy === 1'b0 && qSize(idx) > 0) begin
      e = qPeek(idx);
      if (!e.isDone) check({tag, "_stall_hold"}, {31'd0, so}, {31'd0, e.bitVal});
    end
    if (vld === 1'b0) check({tag, "_so_zero_when_invalid"}, {31'd0, so}, 32'd0);
    if (dn === 1'b1) begin
      if (qSize(idx) == 0) begin
        check({tag, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
        e = qPop(idx);
        check({tag, "_done_order"}, {31'd0, e.isDone}, 32'd1);
      end
    end
  endtask

  always @(negedge CLK) begin
    checkOutput(0, soM, vldM, READY, doneM);
    checkOutput(1, soL, vldL, READY, doneL);
  end

  task automatic checkIdle(input string name);
    check({name, "_msb_idle"}, {28'd0, soM, vldM, busyM, doneM}, 32'd0);
    check({name, "_lsb_idle"}, {28'd0, soL, vldL, busyL, doneL}, 32'd0);
  endtask

  task automatic setCycleInputs(input int cyc, input int mode, input bit holdStart);
    if (!holdStart) START = 1'b0;
    else if (cyc == 4) PDATA = 8'hFF;
    READY = (mode == 0) ? 1'b1 : (((cyc - 1) % 3) == 0);
  endtask

  // Runs from cycle 1 of an unload until DONE, bounded; returns the DONE cycle.
  task automatic waitDone(input int mode, input bit holdStart, output int cyc);
    cyc = 1;
    setCycleInputs(cyc, mode, holdStart);
    while (doneM !== 1'b1 && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
      setCycleInputs(cyc, mode, holdStart);
    end
  endtask

  // mode 0: READY held high; mode 1: READY pattern 1,0,0 repeating.
  task automatic applyStimulus(input logic [7:0] pdata, input int mode,
                               input bit holdStart, input int expDone);
    int cyc;
    pushWord(pdata, 8, 1'b1);
    @(posedge CLK); #1;
    START = 1'b1;
    PDATA = pdata;
    READY = 1'b1;
    @(posedge CLK); #1;
    check("busy_cycle1", {30'd0, busyM, busyL}, 32'd3);
    waitDone(mode, holdStart, cyc);
    check("done_cycle", cyc, expDone);
    check("done_both", {30'd0, doneM, doneL}, 32'd3);
    check("busy_at_done", {30'd0, busyM, busyL}, 32'd0);
    @(posedge CLK); #1;
    checkIdle("after_done");
    if (holdStart) begin
      pushWord(8'hFF, 8, 1'b1);
      READY = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      check("restart_busy", {30'd0, busyM, busyL}, 32'd3);
      waitDone(0, 1'b0, cyc);
      check("restart_done_cycle", cyc, 32'd9);
      @(posedge CLK); #1;
      checkIdle("after_restart");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    checkIdle("reset");
    R = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      check("idle_busy", {30'd0, busyM, busyL}, 32'd0);
    end

    applyStimulus(8'hA5, 0, 1'b0, 9);
    applyStimulus(8'h01, 0, 1'b0, 9);
    applyStimulus(8'hC3, 1, 1'b0, 23);
    applyStimulus(8'h3C, 0, 1'b1, 9);

    // Abort after three accepted bits; the rest of the word must never appear.
    pushWord(8'h96, 3, 1'b0);
    @(posedge CLK); #1;
    START = 1'b1;
    PDATA = 8'h96;
    READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    R = 1'b0;
    READY = 1'b0;
    @(posedge CLK); #1;
    checkIdle("mid_reset");
    R = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check("no_done_after_reset", {30'd0, doneM, doneL}, 32'd0);
    end
    applyStimulus(8'h5A, 0, 1'b0, 9);

    repeat (2) @(posedge CLK);
    #1;
    check("msb_queue_empty", qM.size(), 32'd0);
    check("lsb_queue_empty", qL.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
